// File: rtl/sipo_loader_pkg.sv
// Shared types for the serial-in/parallel-out loader.
package sipo_loader_pkg;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

endpackage

// File: rtl/sipo_bitcounter.sv
// Bit counter for sipo_loader: async clear, sync clear, enable, terminal count at N-1.
module sipo_bitcounter #(
    parameter int N  = 4,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          sclr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    localparam logic [CW-1:0] LP_LAST = CW'(N - 1);

    logic [CW-1:0] r_cnt;
    logic          w_tc;

    assign w_tc = (r_cnt == LP_LAST);

    // Wrapping at terminal count keeps the range 0..N-1 for any N, not just powers of two.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_cnt <= '0;
        end else if (sclr) begin
            r_cnt <= '0;
        end else if (en) begin
            if (w_tc) r_cnt <= '0;
            else      r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;
    assign tc  = w_tc;

endmodule

// File: rtl/sipo_loader.sv
// Serial-in/parallel-out deserializer presenting N-bit words on a valid/ready handshake.
module sipo_loader
    import sipo_loader_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          flush,
    input  logic          in_bit,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [N-1:0]  out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] bit_cnt
);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [N-1:0]   r_shreg;
    logic [N-1:0]   w_shnext;
    logic           w_accept;
    logic           w_tc;

    assign w_accept = in_valid && (r_state == FILL);

    sipo_bitcounter #(
        .N  (N),
        .CW (CW)
    ) u_cnt (
        .clk   (clk),
        .clr_n (clr_n),
        .sclr  (flush),
        .en    (w_accept),
        .cnt   (bit_cnt),
        .tc    (w_tc)
    );

    // A one-bit word has nothing to shift down, so the slice only exists for N > 1.
    if (N == 1) begin : g_one
        assign w_shnext = in_bit;
    end else begin : g_wide
        assign w_shnext = {in_bit, r_shreg[N-1:1]};
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = FILL;
        end else begin
            unique case (r_state)
                FILL: if (w_accept && w_tc) w_state_nxt = FULL;
                FULL: if (out_ready)        w_state_nxt = FILL;
                default:                    w_state_nxt = FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_shreg <= '0;
        end else if (flush) begin
            r_shreg <= '0;
        end else if (w_accept) begin
            r_shreg <= w_shnext;
        end
    end

    assign in_ready  = (r_state == FILL);
    assign out_valid = (r_state == FULL);
    assign out_data  = r_shreg;

endmodule

// File: tb/tb_sipo_loader.sv
// Self-checking bench for sipo_loader: vector table plus scoreboard of expected words.
module tb_sipo_loader;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       flush;
    logic       in_bit;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] bit_cnt;
    logic [3:0] dq;

    int checks   = 0;
    int failures = 0;
    logic [3:0] sb[$];

    always #5 clk = ~clk;

    sipo_loader #(
        .N  (4),
        .CW (3)
    ) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .flush     (flush),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bit_cnt   (bit_cnt)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Downstream register model: loads out_data on every handshake; scoreboard pops there.
    always @(posedge clk) begin
        if (clr_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_handshake actual=%0h required=none at %0t", out_data, $time);
            end else begin
                chk("sb_word", int'(out_data), int'(sb.pop_front()));
            end
            dq <= out_data;
        end
    end

    typedef struct {
        logic       b, v, r, f, push;
        logic [2:0] cnt;
        logic       ir, ov;
        logic [3:0] d;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic b, logic v, logic r, logic f, logic push,
                                logic [2:0] cnt, logic ir, logic ov, logic [3:0] d);
        vec_t x;
        x.b = b; x.v = v; x.r = r; x.f = f; x.push = push;
        x.cnt = cnt; x.ir = ir; x.ov = ov; x.d = d;
        return x;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [3:0] w);
        for (int i = 0; i < 4; i++) begin
            in_bit   = w[i];
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] bits;
        int idx, cyc, nov, first_ov, last_ov;
        logic acc;

        clr_n = 1'b0; flush = 1'b0; in_bit = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #2;
        chk("rst_cnt", bit_cnt, 0);
        chk("rst_ov", out_valid, 0);
        chk("rst_ir", in_ready, 1);
        chk("rst_data", out_data, 0);
        step();
        clr_n = 1'b1;
        step();

        // b v r f push | cnt ir ov data
        tbl.push_back(mk(1,1,0,0,0, 1,1,0,4'h0));
        tbl.push_back(mk(0,1,0,0,0, 2,1,0,4'h0));
        tbl.push_back(mk(1,1,0,0,0, 3,1,0,4'h0));
        tbl.push_back(mk(1,1,0,0,1, 0,0,1,4'b1101));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0,1,0,0,0, 0,0,1,4'b1101));
        tbl.push_back(mk(0,0,1,0,0, 0,1,0,4'h0));
        tbl.push_back(mk(0,1,0,0,0, 1,1,0,4'h0));
        tbl.push_back(mk(0,0,0,0,0, 1,1,0,4'h0));
        tbl.push_back(mk(1,0,0,0,0, 1,1,0,4'h0));
        tbl.push_back(mk(1,1,0,0,0, 2,1,0,4'h0));
        tbl.push_back(mk(0,0,0,0,0, 2,1,0,4'h0));
        tbl.push_back(mk(0,0,0,0,0, 2,1,0,4'h0));
        tbl.push_back(mk(1,1,0,0,0, 3,1,0,4'h0));
        tbl.push_back(mk(1,0,0,0,0, 3,1,0,4'h0));
        tbl.push_back(mk(0,0,0,0,0, 3,1,0,4'h0));
        tbl.push_back(mk(0,1,0,0,1, 0,0,1,4'b0110));
        tbl.push_back(mk(0,0,1,0,0, 0,1,0,4'h0));
        tbl.push_back(mk(1,1,0,0,0, 1,1,0,4'h0));
        tbl.push_back(mk(1,1,0,0,0, 2,1,0,4'h0));
        tbl.push_back(mk(1,1,0,1,0, 0,1,0,4'h0));
        tbl.push_back(mk(0,1,0,0,0, 1,1,0,4'h0));
        tbl.push_back(mk(0,1,0,0,0, 2,1,0,4'h0));
        tbl.push_back(mk(0,1,0,0,0, 3,1,0,4'h0));
        tbl.push_back(mk(1,1,0,0,1, 0,0,1,4'b1000));
        tbl.push_back(mk(0,0,1,0,0, 0,1,0,4'h0));

        foreach (tbl[k]) begin
            in_bit = tbl[k].b; in_valid = tbl[k].v; out_ready = tbl[k].r; flush = tbl[k].f;
            if (tbl[k].push) sb.push_back(tbl[k].d);
            step();
            chk($sformatf("vec%0d_cnt", k), bit_cnt, tbl[k].cnt);
            chk($sformatf("vec%0d_ir", k), in_ready, tbl[k].ir);
            chk($sformatf("vec%0d_ov", k), out_valid, tbl[k].ov);
            if (tbl[k].ov) chk($sformatf("vec%0d_data", k), out_data, tbl[k].d);
        end
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;

        // Flush while FULL with a same-cycle handshake: downstream still takes the word.
        sb.push_back(4'b1101);
        feed(4'b1101);
        chk("ff_ov_pre", out_valid, 1);
        flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
        step();
        flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        chk("ff_ov", out_valid, 0);
        chk("ff_cnt", bit_cnt, 0);
        chk("ff_ir", in_ready, 1);
        chk("ff_dq", dq, 4'b1101);

        // Flush while FULL without handshake discards the word.
        feed(4'b1010);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fn_ov", out_valid, 0);
        chk("fn_cnt", bit_cnt, 0);

        // Asynchronous reset mid-word, between edges.
        in_valid = 1'b1; in_bit = 1'b1; step(); in_bit = 1'b0; step(); in_valid = 1'b0;
        chk("ar_pre_cnt", bit_cnt, 2);
        #2; clr_n = 1'b0; #1;
        chk("ar_mid_cnt", bit_cnt, 0);
        chk("ar_mid_ov", out_valid, 0);
        chk("ar_mid_data", out_data, 0);
        chk("ar_mid_ir", in_ready, 1);
        step(); clr_n = 1'b1;

        // Asynchronous reset while FULL.
        feed(4'b0111);
        chk("ar_full_ov", out_valid, 1);
        #2; clr_n = 1'b0; #1;
        chk("ar_full_ov0", out_valid, 0);
        chk("ar_full_data", out_data, 0);
        chk("ar_full_cnt", bit_cnt, 0);
        step(); clr_n = 1'b1; step();

        sb.push_back(4'b1101);
        feed(4'b1101);
        chk("rec_ov", out_valid, 1);
        chk("rec_data", out_data, 4'b1101);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        chk("rec_ov0", out_valid, 0);

        // Back-to-back words with out_ready held high.
        bits = 8'b1110_0001;
        sb.push_back(4'b0001);
        sb.push_back(4'b1110);
        out_ready = 1'b1;
        idx = 0; cyc = 0; nov = 0; first_ov = -1; last_ov = -1;
        while (cyc < 20) begin
            in_valid = (idx < 8);
            in_bit   = (idx < 8) ? bits[idx] : 1'b0;
            acc      = in_ready && in_valid;
            step();
            cyc++;
            if (acc) idx++;
            if (out_valid) begin
                nov++;
                if (first_ov < 0) first_ov = cyc;
                last_ov = cyc;
                if (nov == 2) chk("b2b_dq_w1", dq, 4'b0001);
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b_bits_taken", idx, 8);
        chk("b2b_ov_cycles", nov, 2);
        chk("b2b_spacing", last_ov - first_ov, 5);
        chk("b2b_dq_w2", dq, 4'b1110);
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
